// File: rtl/clk_div_multi_if.sv
// Divisor programming bus for clk_div_multi: one-cycle write request,
// registered acknowledge and per-channel pending-shadow status.
interface clk_div_multi_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 16
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic             div_wr;
  logic [CHW-1:0]   div_ch;
  logic [CNT_W-1:0] div_val;
  logic             div_ack;
  logic [CH-1:0]    div_pend;

  modport master (output div_wr, div_ch, div_val, input div_ack, div_pend);
  modport slave  (input div_wr, div_ch, div_val, output div_ack, div_pend);
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: CH-channel runtime-programmable clock divider / strobe
// generator. The top decodes the shared divisor write bus; each lane owns
// its counter, active/shadow divisor pair and registered outputs.
module clk_div_multi #(
  parameter int CH      = 4,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 8
) (
  input  logic          clk,
  input  logic          aclr_n,
  input  logic [CH-1:0] en,
  input  logic          sync,
  input  logic [CH-1:0] mode,
  clk_div_multi_if.slave bus,
  output logic [CH-1:0] outclock,
  output logic [CH-1:0] tick
);
  localparam int            CHW  = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CHW:0]  CH_L = (CHW+1)'(CH);

  if (CH < 1 || CH > 16) begin : g_bad_ch
    $error("clk_div_multi: CH must be in 1..16");
  end
  if (DEF_DIV < 2 || longint'(DEF_DIV) >= (longint'(1) << CNT_W)) begin : g_bad_div
    $error("clk_div_multi: DEF_DIV must be >= 2 and < 2**CNT_W");
  end

  logic             wr_ok;
  logic [CNT_W-1:0] wval;
  logic [CH-1:0]    pend;

  // writes aimed past the last channel are dropped; divisors below 2 clamp to 2
  assign wr_ok        = bus.div_wr && ({1'b0, bus.div_ch} < CH_L);
  assign wval         = (bus.div_val < CNT_W'(2)) ? CNT_W'(2) : bus.div_val;
  assign bus.div_pend = pend;

  // acknowledge pulse one cycle after an accepted write
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) bus.div_ack <= 1'b0;
    else         bus.div_ack <= wr_ok;
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    clk_div_lane #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_lane (
      .clk      (clk),
      .aclr_n   (aclr_n),
      .en       (en[i]),
      .sync     (sync),
      .mode     (mode[i]),
      .wr       (wr_ok && (bus.div_ch == CHW'(i))),
      .wval     (wval),
      .pend     (pend[i]),
      .outclock (outclock[i]),
      .tick     (tick[i])
    );
  end
endmodule

// One divider channel. A period starts on leaving idle, on sync, or on the
// wrap from D-1; that is the only point the active divisor may change while
// running, so the output never sees a truncated or stretched phase.
module clk_div_lane #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 8
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             en,
  input  logic             sync,
  input  logic             mode,
  input  logic             wr,
  input  logic [CNT_W-1:0] wval,
  output logic             pend,
  output logic             outclock,
  output logic             tick
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt, act, shd, cnt_inc, half;
  logic             run, start;

  // period-start decode and next-count values; half = ceil(D/2) without overflow
  always_comb begin
    cnt_inc = cnt + CNT_W'(1);
    half    = (act >> 1) + {{(CNT_W-1){1'b0}}, act[0]};
    start   = !run || sync || (cnt == act - CNT_W'(1));
  end

  // counter, divisor pair and registered outputs, all from the next count
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt      <= '0;
      act      <= DEF;
      shd      <= DEF;
      pend     <= 1'b0;
      run      <= 1'b0;
      outclock <= 1'b0;
      tick     <= 1'b0;
    end else if (!en) begin
      // going or staying idle: flush any shadow, a same-cycle write wins
      run      <= 1'b0;
      cnt      <= '0;
      tick     <= 1'b0;
      outclock <= 1'b0;
      pend     <= 1'b0;
      if (wr)        act <= wval;
      else if (pend) act <= shd;
    end else if (start) begin
      // new period: a write landing on this edge bypasses the shadow
      run      <= 1'b1;
      cnt      <= '0;
      tick     <= 1'b1;
      outclock <= 1'b1;
      pend     <= 1'b0;
      if (wr)        act <= wval;
      else if (pend) act <= shd;
    end else begin
      cnt      <= cnt_inc;
      tick     <= 1'b0;
      outclock <= !mode && (cnt_inc < half);
      if (wr) begin
        shd  <= wval;
        pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: a phase/divisor model of every channel is stepped
// on each clock edge and compared with the DUT on every falling edge; directed
// sequences add hand-counted period/duty expectations, then random traffic.
module tb_clk_div_multi;
  localparam int CH = 4, CNT_W = 16, DEF_DIV = 8;

  logic          clk = 1'b0, aclr_n = 1'b0, sync = 1'b0;
  logic [CH-1:0] en = '0, mode = '0, outclock, tick;
  clk_div_multi_if #(.CH(CH), .CNT_W(CNT_W)) bus();

  clk_div_multi #(.CH(CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .aclr_n(aclr_n), .en(en), .sync(sync), .mode(mode),
    .bus(bus), .outclock(outclock), .tick(tick));

  // second instance with a non-power-of-two channel count so div_ch can
  // address a channel that does not exist
  logic       sync2 = 1'b0;
  logic [2:0] en2 = '0, mode2 = '0, outclock2, tick2;
  clk_div_multi_if #(.CH(3), .CNT_W(CNT_W)) bus2();

  clk_div_multi #(.CH(3), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut2 (
    .clk(clk), .aclr_n(aclr_n), .en(en2), .sync(sync2), .mode(mode2),
    .bus(bus2), .outclock(outclock2), .tick(tick2));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // per channel: divisor in use, queued shadow (-1 = none), cycles into period
  int            md[CH], msh[CH], mph[CH];
  bit            mrun[CH];
  logic [CH-1:0] m_out, m_tick, m_pend;
  logic          m_ack;
  bit            m_wr;
  int            m_v;

  always @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int c = 0; c < CH; c++) begin
        md[c] = DEF_DIV; msh[c] = -1; mph[c] = 0; mrun[c] = 0;
      end
      m_out = '0; m_tick = '0; m_pend = '0; m_ack = 1'b0;
    end else begin
      m_ack = bus.div_wr && (int'(bus.div_ch) < CH);
      for (int c = 0; c < CH; c++) begin
        m_wr = bus.div_wr && (int'(bus.div_ch) == c);
        m_v  = (int'(bus.div_val) < 2) ? 2 : int'(bus.div_val);
        if (!en[c]) begin
          if (msh[c] >= 0) md[c] = msh[c];
          if (m_wr) md[c] = m_v;
          msh[c] = -1; mrun[c] = 0; mph[c] = 0;
          m_tick[c] = 1'b0; m_out[c] = 1'b0;
        end else begin
          if (!mrun[c] || sync || mph[c] == md[c] - 1) begin
            if (msh[c] >= 0) md[c] = msh[c];
            if (m_wr) md[c] = m_v;
            msh[c] = -1; mph[c] = 0; mrun[c] = 1;
          end else begin
            mph[c]++;
            if (m_wr) msh[c] = m_v;
          end
          m_tick[c] = (mph[c] == 0);
          m_out[c]  = mode[c] ? m_tick[c] : (mph[c] < (md[c] + 1) / 2);
        end
        m_pend[c] = (msh[c] >= 0);
      end
    end
  end

  // compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    check("outclock", 32'(outclock), 32'(m_out));
    check("tick", 32'(tick), 32'(m_tick));
    check("div_pend", 32'(bus.div_pend), 32'(m_pend));
    check("div_ack", 32'(bus.div_ack), 32'(m_ack));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic write(input int ch, input int val);
    bus.div_wr  = 1'b1;
    bus.div_ch  = 2'(ch);
    bus.div_val = 16'(val);
    @(negedge clk);
    bus.div_wr  = 1'b0;
  endtask

  int hi, tk, oth, n, mis;
  int tcnt[CH];

  initial begin
    bus.div_wr = 1'b0; bus.div_ch = '0; bus.div_val = '0;
    bus2.div_wr = 1'b0; bus2.div_ch = '0; bus2.div_val = '0;
    repeat (2) @(negedge clk);
    check("reset outclock", 32'(outclock), 0);
    check("reset tick", 32'(tick), 0);
    check("reset pend", 32'(bus.div_pend), 0);
    aclr_n = 1'b1;

    // ch0 at default divisor 8: 4 high / 4 low, tick on first enabled edge
    en = 4'b0001;
    hi = 0; tk = 0; oth = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) check("first tick ch0", 32'(tick[0]), 1);
      hi += int'(outclock[0]); tk += int'(tick[0]); oth += int'(outclock[3:1] != 0);
    end
    check("ch0 high cycles", hi, 8);
    check("ch0 ticks", tk, 2);
    check("idle channels quiet", oth, 0);

    // idle ch1 written directly: ack next cycle, nothing pending, period 5
    write(1, 5);
    check("ack after write", 32'(bus.div_ack), 1);
    check("idle write no pend", 32'(bus.div_pend[1]), 0);
    @(negedge clk);
    check("ack one cycle", 32'(bus.div_ack), 0);
    en[1] = 1'b1;
    hi = 0; tk = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      hi += int'(outclock[1]); tk += int'(tick[1]);
    end
    check("ch1 high cycles", hi, 6);
    check("ch1 ticks", tk, 2);

    // running ch0 written at cnt=2: pending 5 cycles, then period 3 (2 hi / 1 lo)
    n = 0;
    while (mph[0] != 2 && n < 40) begin @(negedge clk); n++; end
    check("reach cnt2", 32'(n < 40), 1);
    write(0, 3);
    n = 0;
    while (bus.div_pend[0] && n < 20) begin n++; @(negedge clk); end
    check("pend duration", n, 5);
    hi = 0; tk = 0;
    for (int k = 0; k < 6; k++) begin
      hi += int'(outclock[0]); tk += int'(tick[0]);
      @(negedge clk);
    end
    check("ch0 D3 high", hi, 4);
    check("ch0 D3 ticks", tk, 2);

    // ch2 strobe mode, divisor 1 clamps to 2
    mode[2] = 1'b1;
    write(2, 1);
    en[2] = 1'b1;
    tk = 0; mis = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tk += int'(tick[2]); mis += int'(outclock[2] != tick[2]);
    end
    check("ch2 strobes", tk, 4);
    check("ch2 out==tick", mis, 0);

    // ch0 back to 8 alongside ch1 at 5; sync aligns them, lcm is 40
    write(0, 8);
    repeat (12) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("sync co-tick", 32'(tick[1:0]), 32'h3);
    n = 0;
    do begin @(negedge clk); n++; end while (!(tick[0] && tick[1]) && n < 100);
    check("next co-tick", n, 40);

    // random traffic, checked by the per-cycle model comparison
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) en = 4'($urandom);
      if ($urandom_range(0, 7) == 0) mode = 4'($urandom);
      sync        = ($urandom_range(0, 31) == 0);
      bus.div_wr  = ($urandom_range(0, 3) == 0);
      bus.div_ch  = 2'($urandom_range(0, CH - 1));
      bus.div_val = 16'($urandom_range(0, 12));
    end
    @(negedge clk);
    sync = 1'b0; bus.div_wr = 1'b0; mode = '0; en = '1;
    repeat (6) @(negedge clk);
    write(0, 3);

    // asynchronous reset between edges clears everything at once
    #2 aclr_n = 1'b0;
    #1;
    check("async outclock", 32'(outclock), 0);
    check("async tick", 32'(tick), 0);
    check("async pend", 32'(bus.div_pend), 0);
    check("async ack", 32'(bus.div_ack), 0);
    @(negedge clk);
    en = '1;
    aclr_n = 1'b1;
    for (int c = 0; c < CH; c++) tcnt[c] = 0;
    oth = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) tcnt[c] += int'(tick[c]);
      oth += int'(bus.div_pend != 0);
    end
    for (int c = 0; c < CH; c++) check("post-reset D=8 ticks", tcnt[c], 2);
    check("post-reset pend", oth, 0);

    // out-of-range channel on the 3-channel instance: no ack, no effect
    en2 = 3'b111;
    repeat (3) @(negedge clk);
    bus2.div_wr = 1'b1; bus2.div_ch = 2'd3; bus2.div_val = 16'd3;
    @(negedge clk);
    bus2.div_wr = 1'b0;
    check("oor no ack", 32'(bus2.div_ack), 0);
    check("oor no pend", 32'(bus2.div_pend), 0);
    for (int c = 0; c < 3; c++) tcnt[c] = 0;
    oth = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) tcnt[c] += int'(tick2[c]);
      oth += int'(bus2.div_pend != 0 || bus2.div_ack);
    end
    for (int c = 0; c < 3; c++) check("oor period kept", tcnt[c], 3);
    check("oor status quiet", oth, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel, runtime-programmable clock divider and strobe generator.
- Generalises the fixed single-ratio divider: CH independent channels, each with its own divisor register, enable and output mode (square wave or one-cycle strobe).
- Divisor updates are glitch-free and applied at period boundaries; a common sync input restarts all enabled channels phase-aligned.
- Feeds baud/sample-rate strobes to downstream serial and sampling blocks.

Parameters:
- CH, 4, number of channels (1..16)
- CNT_W, 16, divisor/counter width in bits
- DEF_DIV, 8, reset divisor of every channel; must be >= 2 and < 2^CNT_W, otherwise elaboration error (8 = 2_000_000/250_000)

Ports:
- clk  in  1  system clock
- aclr_n  in  1  asynchronous reset, active-low
- en  in  CH  per-channel enable
- sync  in  1  restart all enabled channels at period start
- mode  in  CH  per channel: 0 = square wave, 1 = strobe
- div_wr  in  1  divisor write request, one cycle
- div_ch  in  max(1,$clog2(CH))  target channel of the write
- div_val  in  CNT_W  divisor value to write
- div_ack  out  1  one-cycle pulse, the cycle after an accepted write
- div_pend  out  CH  shadow divisor waiting for the next period boundary
- outclock  out  CH  divided output
- tick  out  CH  one-cycle pulse at the start of each period

Behaviour:
- Reset (aclr_n=0, asynchronous):
  - all counters 0; active and shadow divisors = DEF_DIV
  - div_pend, outclock, tick, div_ack = 0 immediately, without waiting for a clock edge
  - all channels idle
- Per channel, divisor D (active register), counter cnt from 0 to D-1.
- Idle (en=0):
  - cnt = 0; outclock and tick = 0 from the next edge
  - leaving idle: first edge with en=1 sets cnt=0, tick=1, outclock=1 (strobe mode also 1)
- Running (en=1), each edge:
  - cnt = (cnt==D-1) ? 0 : cnt+1
  - tick=1 only on the edge that loads cnt=0
- Square mode: outclock=1 while cnt < ceil(D/2), 0 otherwise. Odd D gives the extra cycle in the high phase.
- Strobe mode: outclock = tick.
- All outputs are registered: next-state logic is computed from the next cnt, so there is no combinational decode on output pins.
- Mode change mid-period takes effect on the next edge; cnt is not disturbed.
- Divisor writes:
  - div_wr with div_ch < CH is accepted; div_ack=1 on the following cycle.
  - div_ch >= CH: write ignored, no ack.
  - div_val < 2 is clamped to 2.
  - Channel idle: active divisor updated directly; div_pend stays 0.
  - Channel running: value goes to the shadow register, div_pend[ch]=1. At the next wrap (cnt D-1 -> 0) or sync restart, active <= shadow and div_pend clears.
  - Write in the same cycle as that channel's wrap: the new value becomes active at this wrap (bypass); div_pend stays 0.
  - A second write before the boundary overwrites the shadow; only the last value is applied.
- Disable mid-period: channel goes idle at the next edge. Any pending shadow is applied to active and div_pend clears.
- sync=1 at an edge:
  - every enabled channel loads cnt=0, tick=1, outclock=1, and applies its pending shadow
  - idle channels are unaffected
  - sync overrides a same-cycle wrap; the result is identical
- Widths: cnt and divisor are unsigned CNT_W bits. ceil(D/2) = (D>>1) + D[0], computed without overflow at D = 2^CNT_W-1.

Test Plan:
- Release reset, en=4'b0001, mode=0, DEF_DIV=8 -> outclock[0] high 4 / low 4 cycles, tick[0] every 8 cycles starting on the first enabled edge; other channels stay 0.
- Idle ch1, write div_val=5, then en[1]=1 -> div_ack one cycle after the write, div_pend[1]=0; outclock[1] high 3 / low 2, period 5.
- Ch0 running D=8: write 3 at cnt=2 -> div_pend[0]=1 for 5 cycles, clears at wrap; the following periods are 3 cycles (high 2 / low 1).
- Write div_val=1 to ch2 (mode=1), write div_ch=CH -> ch2 period 2 with a one-cycle strobe every 2 cycles; the out-of-range write produces no div_ack and no state change.
- Ch0 D=8 and ch1 D=5 running out of phase, pulse sync -> both tick on the same edge; the next coincident ticks occur 40 cycles later.
- Assert aclr_n low mid-period, asynchronously, between clock edges -> all outputs 0 before the next clk edge; after release, divisors are back to 8 and div_pend=0.
